// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register: valid/ready handshake, optional
// two-entry skid buffer, flush squash and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 12,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam bit UseSkid = (SKID != 0);

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic              rdy_q, rdy_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic              fire_in, fire_out;

    assign in_ready   = UseSkid ? rdy_q : (!m_valid_q || out_ready);
    assign fire_in    = in_valid && in_ready;
    assign fire_out   = m_valid_q && out_ready;
    assign out_valid  = m_valid_q;
    assign out_data   = m_data_q;
    assign out_ctrl   = m_valid_q ? m_ctrl_q : '0;
    assign occupancy  = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    assign bubble_cnt = bubble_q;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ctrl_d  = m_ctrl_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_ctrl_d  = s_ctrl_q;
        bubble_d  = bubble_q;

        if (out_ready && !m_valid_q && (bubble_q != '1)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end

        if (flush) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_ctrl_d  = '0;
            s_valid_d = 1'b0;
            s_data_d  = '0;
            s_ctrl_d  = '0;
        end else if (UseSkid) begin
            // in_ready is low while S is full, so no accept can race the drain
            if (s_valid_q) begin
                if (fire_out) begin
                    m_data_d  = s_data_q;
                    m_ctrl_d  = s_ctrl_q;
                    s_valid_d = 1'b0;
                end
            end else if (fire_in && (!m_valid_q || fire_out)) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
                m_ctrl_d  = in_ctrl;
            end else if (fire_in) begin
                s_valid_d = 1'b1;
                s_data_d  = in_data;
                s_ctrl_d  = in_ctrl;
            end else if (fire_out) begin
                m_valid_d = 1'b0;
            end
        end else begin
            if (fire_in) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
                m_ctrl_d  = in_ctrl;
            end else if (fire_out) begin
                m_valid_d = 1'b0;
            end
        end

        rdy_d = !s_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ctrl_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_ctrl_q  <= '0;
            rdy_q     <= 1'b1;
            bubble_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ctrl_q  <= m_ctrl_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_ctrl_q  <= s_ctrl_d;
            rdy_q     <= rdy_d;
            bubble_q  <= bubble_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 and SKID=1 instances side by side,
// checked against a small counted-FIFO model of the stage.
module tb_pipe_stage_reg;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int NW = 4;
    localparam int BMAX = (1 << NW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    fl, iv, ir, ov, orr;
    logic [DW-1:0] id [2];
    logic [CW-1:0] ic [2];
    logic [DW-1:0] od [2];
    logic [CW-1:0] oc [2];
    logic [1:0]    occ [2];
    logic [NW-1:0] bc [2];

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u0 (
        .clk(clk), .reset(rst), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .in_ctrl(ic[0]),
        .out_valid(ov[0]), .out_ready(orr[0]),
        .out_data(od[0]), .out_ctrl(oc[0]),
        .occupancy(occ[0]), .bubble_cnt(bc[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u1 (
        .clk(clk), .reset(rst), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .in_ctrl(ic[1]),
        .out_valid(ov[1]), .out_ready(orr[1]),
        .out_data(od[1]), .out_ctrl(oc[1]),
        .occupancy(occ[1]), .bubble_cnt(bc[1])
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: a FIFO of capacity 2 (SKID=1) or 1 (SKID=0) per instance
    int            cnt [2];
    int            bub [2];
    logic [DW-1:0] md [2][2];
    logic [CW-1:0] mc [2][2];
    logic [DW-1:0] hold [2];
    bit            ready_known = 1'b0;

    function automatic bit exp_rdy(int k);
        if (k == 1) return cnt[k] < 2;
        return (cnt[k] == 0) || orr[k];
    endfunction

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[skid%0d]: observed %0h expected %0h",
                   tag, k, obs, exp);
        end
    endtask

    task automatic drv(bit v, logic [DW-1:0] d, logic [CW-1:0] c,
                       bit r, bit f);
        iv    = {v, v};
        id[0] = d;
        id[1] = d;
        ic[0] = c;
        ic[1] = c;
        orr   = {r, r};
        fl    = {f, f};
    endtask

    task automatic cyc();
        bit er [2];
        for (int k = 0; k < 2; k++) er[k] = exp_rdy(k);
        #1;
        if (ready_known) begin
            for (int k = 0; k < 2; k++)
                chk("in_ready", k, 32'(ir[k]), 32'(er[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                cnt[k]  = 0;
                bub[k]  = 0;
                hold[k] = '0;
            end else begin
                if (orr[k] && cnt[k] == 0 && bub[k] < BMAX) bub[k]++;
                if (fl[k]) begin
                    cnt[k]  = 0;
                    hold[k] = '0;
                end else begin
                    if (cnt[k] > 0 && orr[k]) begin
                        md[k][0] = md[k][1];
                        mc[k][0] = mc[k][1];
                        cnt[k]--;
                    end
                    if (iv[k] && er[k]) begin
                        md[k][cnt[k]] = id[k];
                        mc[k][cnt[k]] = ic[k];
                        cnt[k]++;
                    end
                    if (cnt[k] > 0) hold[k] = md[k][0];
                end
            end
        end
        ready_known = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("out_valid", k, 32'(ov[k]), 32'(cnt[k] > 0));
            chk("out_data", k, 32'(od[k]), 32'(hold[k]));
            chk("out_ctrl", k, 32'(oc[k]),
                cnt[k] > 0 ? 32'(mc[k][0]) : 32'd0);
            chk("occupancy", k, 32'(occ[k]), 32'(cnt[k]));
            chk("bubble_cnt", k, 32'(bc[k]), 32'(bub[k]));
        end
    endtask

    initial begin
        rst = 1'b1;
        drv(1'b1, 16'h1234, 4'hF, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        drv(1'b0, '0, '0, 1'b0, 1'b0);
        cyc();

        // streaming
        drv(1'b1, 16'h11, 4'h1, 1'b1, 1'b0); cyc();
        drv(1'b1, 16'h22, 4'h2, 1'b1, 1'b0); cyc();
        drv(1'b1, 16'h33, 4'h3, 1'b1, 1'b0); cyc();
        drv(1'b1, 16'h44, 4'h4, 1'b1, 1'b0); cyc();
        drv(1'b0, '0, '0, 1'b1, 1'b0); cyc();
        cyc();

        // backpressure, C held until accepted
        drv(1'b1, 16'hA, 4'h2, 1'b0, 1'b0); cyc();
        drv(1'b1, 16'hB, 4'h3, 1'b0, 1'b0); cyc();
        drv(1'b1, 16'hC, 4'h4, 1'b0, 1'b0); cyc();
        cyc();
        drv(1'b1, 16'hC, 4'h4, 1'b1, 1'b0); cyc();
        cyc();
        drv(1'b0, '0, '0, 1'b1, 1'b0); cyc();
        cyc();

        // flush while full
        drv(1'b1, 16'h21, 4'h5, 1'b0, 1'b0); cyc();
        drv(1'b1, 16'h22, 4'h6, 1'b0, 1'b0); cyc();
        drv(1'b1, 16'h55, 4'h7, 1'b0, 1'b1); cyc();
        drv(1'b0, '0, '0, 1'b0, 1'b0); cyc();
        drv(1'b0, '0, '0, 1'b1, 1'b0); cyc();

        // reset with two entries held
        drv(1'b1, 16'h31, 4'h1, 1'b0, 1'b0); cyc();
        drv(1'b1, 16'h32, 4'h2, 1'b0, 1'b0); cyc();
        rst = 1'b1;
        drv(1'b1, 16'h33, 4'h3, 1'b1, 1'b0); cyc();
        rst = 1'b0;
        drv(1'b0, '0, '0, 1'b0, 1'b0); cyc();

        // bubble saturation, then flush must not clear it
        drv(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (20) cyc();
        drv(1'b0, '0, '0, 1'b1, 1'b1); cyc();
        drv(1'b0, '0, '0, 1'b1, 1'b0); cyc();

        // SKID=0 passthrough: ready follows out_ready in the same cycle
        drv(1'b1, 16'h61, 4'h9, 1'b0, 1'b0); cyc();
        drv(1'b1, 16'h62, 4'hA, 1'b1, 1'b0); cyc();
        drv(1'b0, '0, '0, 1'b1, 1'b0); cyc();

        repeat (400) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]  = ($urandom_range(0, 3) != 0);
                id[k]  = DW'($urandom);
                ic[k]  = CW'($urandom);
                orr[k] = ($urandom_range(0, 2) != 0);
                fl[k]  = ($urandom_range(0, 15) == 0);
            end
            rst = ($urandom_range(0, 63) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic inter-stage pipeline register for the 5-stage CPU. It generalises the fixed-field stage registers into one block with a configurable data and control width. It replaces the stall/flush pins with a valid/ready handshake, and has an optional two-entry skid buffer so `in_ready` can be fully registered. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and also provides a saturating bubble counter for performance monitoring.

## Interface
Parameters:
- `DATA_W`, default 96: width of the datapath payload (operands, immediate, PC+4, register indices).
- `CTRL_W`, default 12: width of the control bundle (RegWrite, MemRead, MemWrite, ALUOp, …). It is zeroed on flush and reset.
- `SKID`, default 1: 1 selects a two-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.
- `CNT_W`, default 16: width of the bubble counter.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  squashes all held entries (branch/jump redirect).
- `in_valid`  in  1  upstream stage presents an instruction.
- `in_ready`  out  1  this stage can accept an instruction.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `out_valid`  out  1  the head entry is valid.
- `out_ready`  in  1  downstream stage accepts the head entry.
- `out_data`  out  DATA_W  head entry payload.
- `out_ctrl`  out  CTRL_W  head entry control; forced to 0 whenever `out_valid`=0.
- `occupancy`  out  2  number of held entries: 0..2, or 0..1 when SKID=0.
- `bubble_cnt`  out  CNT_W  saturating count of bubble cycles.

## Operation
Definitions:
- `fire_in` = `in_valid` & `in_ready`.
- `fire_out` = `out_valid` & `out_ready`.
- Internal entries: M (head, drives the outputs) and S (skid, present only when SKID=1).

Priority, highest first: `reset`, then `flush`, then normal operation.

Reset:
- M and S are invalidated.
- `out_data`, `out_ctrl` = 0; `occupancy` = 0; `bubble_cnt` = 0.
- `in_ready` = 1 in the cycle after reset.

Flush:
- M and S are invalidated; stored data and ctrl are cleared to 0.
- Any `fire_in` in the same cycle is discarded.
- `bubble_cnt` is not cleared by flush.

SKID=1:
- `in_ready` = !S.valid, taken straight from a flop.
- If S is valid: on `fire_out`, M ← S and S is invalidated. No input is accepted.
- If S is empty:
  - `fire_in` & (!M.valid | `fire_out`): M ← input.
  - `fire_in` & M.valid & !`fire_out`: S ← input.
  - !`fire_in` & `fire_out`: M is invalidated.
- Ordering is strictly FIFO; M is always older than S.

SKID=0:
- `in_ready` = !M.valid | `out_ready` (combinational).
- On `fire_in`, M ← input.
- Otherwise, on `fire_out`, M is invalidated.

Bubble counter:
- Increments when `out_ready` & !`out_valid` and not in reset.
- Holds at 2^CNT_W−1; it never wraps.

Other rules:
- Data and ctrl registers load only on the transfers above; they hold otherwise, with no X propagation.
- An invalid entry always presents `out_ctrl` = 0, so a bubble can never assert RegWrite or MemWrite downstream.

## Timing
- Latency: an instruction accepted at edge N is visible on `out_*` after edge N, i.e. one cycle.
- Throughput: one instruction per cycle with `out_ready` held high, for both SKID values.
- SKID=1 backpressure:
  - `in_ready` falls one cycle after the first un-drained accept while M is full.
  - At most two entries are ever held.
  - `in_ready` rises in the cycle after S drains into M.
- SKID=0: `in_ready` has a combinational path from `out_ready`. SKID=1 has no such path.
- Simultaneous events:
  - `fire_in` and `fire_out` with one entry held: occupancy stays 1 and M is replaced.
  - `flush` together with `fire_out`: the downstream transfer completes this cycle, and the entry is invalid the next cycle.
- Reset in mid-operation with two entries held: everything is cleared after one edge and no partial transfer survives.

## Test plan
- Reset: assert `reset` for 2 cycles with `in_valid`=1 → `out_valid`=0, `out_ctrl`=0, `occupancy`=0, `bubble_cnt`=0; `in_ready`=1 in the first cycle after release.
- Streaming: SKID=1, `out_ready`=1, push D0..D3 (0x11, 0x22, 0x33, 0x44) on consecutive cycles → the same values appear on `out_data` in order one cycle later each, with no gaps and `occupancy`=1 throughout.
- Backpressure: SKID=1, `out_ready`=0, push A=0xA, B=0xB → `occupancy`=2 and `in_ready`=0. Offer C=0xC and hold. Raise `out_ready` → outputs A, then B, then C on consecutive cycles; C is never lost.
- Flush while full: two entries held, pulse `flush` with `in_valid`=1 (D=0x55) → next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, and 0x55 never appears on `out_data`.
- Bubble saturation: CNT_W=4, `out_ready`=1, `in_valid`=0 for 20 cycles → `bubble_cnt` counts 1..15 and holds at 15; a later flush leaves it at 15.
- SKID=0 passthrough: `out_valid`=1 held; toggling `out_ready` 0→1 raises `in_ready` in the same cycle, and a new entry replaces M at the next edge.
